// File: rtl/dot_product_mac_if.sv
// Operand/control/result bundle between a feeder and the dot-product engine.
// The feeder owns start/length/operands; the engine owns handshake and result.
interface dot_product_mac_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              in_valid;
    logic              in_ready;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              overflow;

    // Feeder side: drives the request and operand stream.
    modport master (
        output start, vec_len, a_in, b_in, in_valid,
        input  in_ready, busy, result, result_valid, overflow
    );

    // Engine side: consumes operands and presents the result.
    modport slave (
        input  start, vec_len, a_in, b_in, in_valid,
        output in_ready, busy, result, result_valid, overflow
    );
endinterface

// File: rtl/dot_product_mac.sv
// Unsigned multiply-accumulate engine: sums a_in*b_in over vec_len accepted
// beats and presents the low DATA_W bits of the sum with a one-cycle
// result_valid pulse that loads the downstream result register.
module dot_product_mac #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,   // asynchronous, active-low
    dot_product_mac_if.slave     bus
);
    localparam int ACC_W = 2 * DATA_W + LEN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ACC_W-1:0]    r_acc;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    r_len_q;

    logic                w_beat;
    logic                w_last;
    logic [2*DATA_W-1:0] w_prod;

    // Full-width product: operands are zero-extended so nothing is lost.
    assign w_prod = {{DATA_W{1'b0}}, bus.a_in} * {{DATA_W{1'b0}}, bus.b_in};
    assign w_beat = (r_state == ACCUM) && bus.in_valid;
    assign w_last = (r_count == r_len_q - 1'b1);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE, DONE lasts one cycle.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch forms.
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = (bus.vec_len != '0) ? ACCUM : DONE;
            ACCUM:   if (w_beat && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Accumulator, beat counter and captured length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_count <= '0;
            r_len_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        if (bus.vec_len != '0) begin
                            r_len_q <= bus.vec_len;
                            r_count <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= r_acc + {{LEN_W{1'b0}}, w_prod};
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free
    // and take their reset values the moment reset asserts.
    assign bus.in_ready     = (r_state == ACCUM);
    assign bus.busy         = (r_state != IDLE);
    assign bus.result_valid = (r_state == DONE);
    assign bus.result       = r_acc[DATA_W-1:0];
    assign bus.overflow     = |r_acc[ACC_W-1:DATA_W];
endmodule

// File: tb/tb_dot_product_mac.sv
// Directed bench for dot_product_mac: hand-computed dot products, handshake
// gaps, truncation/overflow, zero length, mid-run reset and back-to-back runs.
module tb_dot_product_mac;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_bad;

    dot_product_mac_if #(.DATA_W(16), .LEN_W(8)) bus ();

    dot_product_mac #(.DATA_W(16), .LEN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for one cycle, then scramble vec_len to show it is ignored.
    task automatic start_op(input logic [7:0] len);
        bus.start   = 1'b1;
        bus.vec_len = len;
        tick();
        bus.start   = 1'b0;
        bus.vec_len = 8'h5A;
    endtask

    // Deliver one pair in a cycle where the engine must be ready.
    task automatic beat(input logic [15:0] a, input logic [15:0] b);
        check("in_ready_on_beat", bus.in_ready, 1'b1);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a_in     = 16'hDEAD;
        bus.b_in     = 16'hBEEF;
    endtask

    // Called right after the last accepting edge: expect DONE now, IDLE next.
    task automatic expect_done(input string tag, input logic [15:0] res,
                               input logic ovf);
        check({tag, "_valid"},    bus.result_valid, 1'b1);
        check({tag, "_result"},   bus.result, res);
        check({tag, "_overflow"}, bus.overflow, ovf);
        check({tag, "_rdy_low"},  bus.in_ready, 1'b0);
        tick();
        check({tag, "_pulse_end"}, bus.result_valid, 1'b0);
        check({tag, "_idle"},      bus.busy, 1'b0);
        check({tag, "_held"},      bus.result, res);
    endtask

    initial begin
        n_checks     = 0;
        n_bad        = 0;
        bus.start    = 1'b0;
        bus.vec_len  = 8'd0;
        bus.a_in     = 16'd0;
        bus.b_in     = 16'd0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #2 reset     = 1'b0;
        tick();
        tick();

        // Reset values.
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_busy",     bus.busy, 1'b0);
        check("rst_result",   bus.result, 16'd0);
        check("rst_valid",    bus.result_valid, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        reset = 1'b1;
        tick();

        // 1*2 + 3*4 + 5*6 = 44 on consecutive beats.
        start_op(8'd3);
        check("t1_busy", bus.busy, 1'b1);
        beat(16'd1, 16'd2);
        beat(16'd3, 16'd4);
        check("t1_no_early_valid", bus.result_valid, 1'b0);
        beat(16'd5, 16'd6);
        expect_done("t1", 16'd44, 1'b0);

        // in_valid while IDLE must not accumulate.
        bus.in_valid = 1'b1;
        bus.a_in     = 16'd100;
        bus.b_in     = 16'd100;
        tick();
        bus.in_valid = 1'b0;
        check("idle_beat_ignored", bus.result, 16'd44);

        // 2*3 + 4*5 = 26 with two idle cycles between beats.
        start_op(8'd2);
        beat(16'd2, 16'd3);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t2_gap_ready", bus.in_ready, 1'b1);
            check("t2_gap_novalid", bus.result_valid, 1'b0);
        end
        beat(16'd4, 16'd5);
        expect_done("t2", 16'd26, 1'b0);

        // 0xFFFF*0xFFFF + 1 = 0xFFFE0002 -> truncated 0x0002 with overflow.
        start_op(8'd2);
        beat(16'hFFFF, 16'hFFFF);
        beat(16'd1, 16'd1);
        expect_done("t3", 16'h0002, 1'b1);

        // Zero length: DONE directly after the start edge, zero result.
        start_op(8'd0);
        expect_done("t4", 16'd0, 1'b0);

        // Partial run, ignored restart, then reset discards the partial sum.
        start_op(8'd4);
        beat(16'd1, 16'd1);
        beat(16'd2, 16'd2);
        bus.start   = 1'b1;
        bus.vec_len = 8'd1;
        tick();
        bus.start   = 1'b0;
        check("t5_start_ignored_busy", bus.busy, 1'b1);
        check("t5_start_ignored_rdy",  bus.in_ready, 1'b1);
        check("t5_partial_sum",        bus.result, 16'd5);
        reset = 1'b0;
        #1;
        check("t5_rst_busy",   bus.busy, 1'b0);
        check("t5_rst_result", bus.result, 16'd0);
        check("t5_rst_valid",  bus.result_valid, 1'b0);
        tick();
        check("t5_rst_no_pulse", bus.result_valid, 1'b0);
        reset = 1'b1;
        tick();
        start_op(8'd1);
        beat(16'd7, 16'd8);

        // 56 completes; start raised in the DONE cycle is ignored, then held
        // into the following IDLE cycle where it is accepted.
        check("t6_valid", bus.result_valid, 1'b1);
        check("t6_result", bus.result, 16'd56);
        bus.start   = 1'b1;
        bus.vec_len = 8'd1;
        tick();
        check("t6_done_start_ignored", bus.busy, 1'b0);
        check("t6_held_until_start",   bus.result, 16'd56);
        tick();
        bus.start   = 1'b0;
        bus.vec_len = 8'h5A;
        check("t6_restart_accum", bus.in_ready, 1'b1);
        check("t6_acc_cleared",   bus.result, 16'd0);
        beat(16'd9, 16'd9);
        expect_done("t6", 16'd81, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
